// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO data memory: register offsets and
// the hex-to-7-segment table (segments g..a, active-low).
package mmio_pkg;

    localparam int OFS_BTN_STATUS = 0;
    localparam int OFS_BTN_LEVEL  = 1;
    localparam int OFS_LED        = 2;
    localparam int OFS_DIG0       = 3;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex7(input logic [3:0] v);
        return HEX7[v];
    endfunction

endpackage

// File: rtl/mmio_memory_btn_capture.sv
// One button input: 2-flop synchroniser, press-edge pulse and level.
// MMIO_DEBOUNCE_EN adds a stability counter in front of the edge detect.
module btn_capture (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press
);

`ifdef MMIO_DEBOUNCE_EN
    parameter int DEB_CYCLES = 8;
    localparam int DW = $clog2(DEB_CYCLES);
`endif

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic w_sync;

    // synchronise the raw active-low pin; reset reads as released
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_btn_n;
            r_s2 <= r_s1;
        end
    end

    assign w_sync = ~r_s2;

`ifdef MMIO_DEBOUNCE_EN
    logic          r_db;
    logic [DW-1:0] r_cnt;

    // accept a new level only after DEB_CYCLES differing samples in a row
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (w_sync != r_db) begin
            if (r_cnt == DW'(DEB_CYCLES - 1)) begin
                r_db  <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_level = r_db;
`else
    assign o_level = w_sync;
`endif

    // previous level for the rising-edge (press) detector
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= o_level;
        end
    end

    assign o_press = o_level & ~r_prev;

endmodule

// File: rtl/mmio_memory.sv
// Data RAM plus I/O window: sticky button flags, LED register, hex display scanner.
// Optional button debounce is enabled by defining MMIO_DEBOUNCE_EN.
module mmio_memory
    import mmio_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 8,
    parameter int                RAM_DEPTH  = 240,
    parameter logic [ADDR_W-1:0] IO_BASE    = 8'hF0,
    parameter int                NUM_BTN    = 4,
    parameter int                NUM_DIG    = 4,
    parameter int                SCAN_DIV   = 16,
    parameter int                DEB_CYCLES = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_di,
    output logic [DATA_W-1:0] o_do,
    input  logic [NUM_BTN-1:0] i_btn_n,
    output logic [DATA_W-1:0] o_led,
    output logic [6:0]        o_seg_n,
    output logic [NUM_DIG-1:0] o_dig_n
);

    localparam int IDX_W  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] A_RAM_END = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] A_STATUS  = IO_BASE + ADDR_W'(OFS_BTN_STATUS);
    localparam logic [ADDR_W-1:0] A_LEVEL   = IO_BASE + ADDR_W'(OFS_BTN_LEVEL);
    localparam logic [ADDR_W-1:0] A_LED     = IO_BASE + ADDR_W'(OFS_LED);
    localparam logic [ADDR_W-1:0] A_DIG0    = IO_BASE + ADDR_W'(OFS_DIG0);

    if (DATA_W < 8 || RAM_DEPTH > int'(IO_BASE) || NUM_BTN < 1 ||
        NUM_BTN > DATA_W || NUM_DIG < 1 || NUM_DIG > 8 ||
        SCAN_DIV < 2 || DEB_CYCLES < 2) begin : g_bad_param
        $error("mmio_memory: illegal parameter combination");
    end

    logic [DATA_W-1:0]  r_ram [RAM_DEPTH];
    logic [DATA_W-1:0]  r_led;
    logic [DATA_W-1:0]  r_dig [NUM_DIG];
    logic [NUM_BTN-1:0] r_flag;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [6:0]         r_seg_n;
    logic [NUM_DIG-1:0] r_dig_n;

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_clr;
    logic               w_is_ram;
    logic               w_is_status;
    logic               w_is_level;
    logic               w_is_led;
    logic               w_is_dig;
    logic [ADDR_W-1:0]  w_dig_ofs;
    logic [IDX_W-1:0]   w_dig_sel;
    logic               w_tick;
    logic [IDX_W-1:0]   w_nidx;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_capture
`ifdef MMIO_DEBOUNCE_EN
        #(.DEB_CYCLES(DEB_CYCLES))
`endif
        u_btn (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_btn_n (i_btn_n[b]),
            .o_level (w_level[b]),
            .o_press (w_press[b])
        );
    end

    assign w_is_ram    = i_addr < A_RAM_END;
    assign w_is_status = i_addr == A_STATUS;
    assign w_is_level  = i_addr == A_LEVEL;
    assign w_is_led    = i_addr == A_LED;
    assign w_dig_ofs   = i_addr - A_DIG0;
    assign w_is_dig    = (i_addr >= A_DIG0) &&
                         (w_dig_ofs < ADDR_W'(NUM_DIG));
    assign w_dig_sel   = w_dig_ofs[IDX_W-1:0];

    // combinational read port; unmapped addresses read as zero
    always_comb begin
        o_do = '0;
        unique case (1'b1)
            w_is_ram:    o_do = r_ram[i_addr[RAM_AW-1:0]];
            w_is_status: o_do = DATA_W'(r_flag);
            w_is_level:  o_do = DATA_W'(w_level);
            w_is_led:    o_do = r_led;
            w_is_dig:    o_do = r_dig[w_dig_sel];
            default:     o_do = '0;
        endcase
    end

    // RAM contents survive reset
    always_ff @(posedge i_clk) begin
        if (i_we && w_is_ram) begin
            r_ram[i_addr[RAM_AW-1:0]] <= i_di;
        end
    end

    assign w_clr = (i_we && w_is_status) ? i_di[NUM_BTN-1:0] : '0;

    // I/O registers; a press in the same cycle as a clear keeps the flag set
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_flag <= '0;
            r_led  <= '0;
            for (int k = 0; k < NUM_DIG; k++) begin
                r_dig[k] <= '0;
            end
        end else begin
            r_flag <= (r_flag & ~w_clr) | w_press;
            if (i_we && w_is_led) begin
                r_led <= i_di;
            end
            if (i_we && w_is_dig) begin
                r_dig[w_dig_sel] <= i_di;
            end
        end
    end

    assign w_tick = r_cnt == CNT_W'(SCAN_DIV - 1);
    assign w_nidx = (r_idx == IDX_W'(NUM_DIG - 1)) ? '0 : r_idx + 1'b1;

    // digit scanner: advance one digit per prescaler wrap, latch its pattern
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt   <= '0;
            r_idx   <= IDX_W'(NUM_DIG - 1);
            r_seg_n <= SEG_OFF;
            r_dig_n <= '1;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx   <= w_nidx;
                r_dig_n <= ~(NUM_DIG'(1) << w_nidx);
                r_seg_n <= hex7(r_dig[w_nidx][3:0]);
            end
        end
    end

    assign o_led   = r_led;
    assign o_seg_n = r_seg_n;
    assign o_dig_n = r_dig_n;

endmodule

// File: tb/tb_mmio_memory.sv
// Self-checking bench for mmio_memory: vector table, random traffic
// against a map-level model, and hand-written button/scan/reset sequences.
module tb_mmio_memory;

    localparam int RAM_DEPTH = 240;
    localparam int NUM_DIG   = 4;
    localparam int DEB       = 8;
`ifdef MMIO_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 1;
`else
    localparam int LAT = 3;
`endif
    localparam logic [7:0] IO = 8'hF0;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [7:0] addr;
    logic [7:0] di;
    logic [7:0] dout;
    logic [3:0] btn_n;
    logic [7:0] led;
    logic [6:0] seg_n;
    logic [3:0] dig_n;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [7:0] m_ram [256];
    bit         m_known [256];
    logic [7:0] m_led;
    logic [7:0] m_dig [NUM_DIG];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] di;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    mmio_memory #(
        .DATA_W(8), .ADDR_W(8), .RAM_DEPTH(RAM_DEPTH), .IO_BASE(IO),
        .NUM_BTN(4), .NUM_DIG(NUM_DIG), .SCAN_DIV(16), .DEB_CYCLES(DEB)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (we),
        .i_addr  (addr),
        .i_di    (di),
        .o_do    (dout),
        .i_btn_n (btn_n),
        .o_led   (led),
        .o_seg_n (seg_n),
        .o_dig_n (dig_n)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        we = 1'b1;
        addr = a;
        di = d;
        step();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a,
                          input logic [7:0] exp);
        addr = a;
        #1;
        check(nm, dout, exp);
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        int o;
        o = int'(a) - int'(IO) - 3;
        if (int'(a) < RAM_DEPTH) return m_ram[a];
        if (a == IO + 8'd2) return m_led;
        if (o >= 0 && o < NUM_DIG) return m_dig[o];
        return 8'h00;
    endfunction

    task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
        int o;
        o = int'(a) - int'(IO) - 3;
        if (int'(a) < RAM_DEPTH) begin
            m_ram[a] = d;
            m_known[a] = 1'b1;
        end else if (a == IO + 8'd2) begin
            m_led = d;
        end else if (o >= 0 && o < NUM_DIG) begin
            m_dig[o] = d;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        logic       w;

        rst = 1'b0;
        we = 1'b0;
        addr = 8'h00;
        di = 8'h00;
        btn_n = 4'hF;
        step();
        step();
        check("rst_seg", seg_n, 7'h7F);
        check("rst_dig", dig_n, 4'hF);
        check("rst_led", led, 8'h00);
        rst = 1'b1;
        rd_chk("rst_status", IO, 8'h00);

        // register/RAM vectors: read value is sampled before the edge
        vt.push_back('{1'b1, 8'h10, 8'hA5, 1'b0, 8'h00});
        vt.push_back('{1'b0, 8'h10, 8'h00, 1'b1, 8'hA5});
        vt.push_back('{1'b0, 8'hF9, 8'h00, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'hF9, 8'h55, 1'b1, 8'h00});
        vt.push_back('{1'b0, 8'hF9, 8'h00, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'hF2, 8'h3C, 1'b1, 8'h00});
        vt.push_back('{1'b0, 8'hF2, 8'h00, 1'b1, 8'h3C});
        vt.push_back('{1'b1, 8'hF3, 8'h01, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'hF4, 8'h02, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'hF5, 8'h03, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'hF6, 8'h0F, 1'b1, 8'h00});
        vt.push_back('{1'b0, 8'hF3, 8'h00, 1'b1, 8'h01});
        vt.push_back('{1'b0, 8'hF4, 8'h00, 1'b1, 8'h02});
        vt.push_back('{1'b0, 8'hF5, 8'h00, 1'b1, 8'h03});
        vt.push_back('{1'b0, 8'hF6, 8'h00, 1'b1, 8'h0F});
        vt.push_back('{1'b0, 8'hF7, 8'h00, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'hF1, 8'hFF, 1'b1, 8'h00});
        vt.push_back('{1'b0, 8'hF1, 8'h00, 1'b1, 8'h00});
        vt.push_back('{1'b0, 8'hF0, 8'h00, 1'b1, 8'h00});
        vt.push_back('{1'b0, 8'h10, 8'h00, 1'b1, 8'hA5});
        for (int i = 0; i < vt.size(); i++) begin
            we = vt[i].we;
            addr = vt[i].addr;
            di = vt[i].di;
            #1;
            if (vt[i].chk) check($sformatf("vec%0d", i), dout, vt[i].exp);
            step();
        end
        we = 1'b0;
        check("led_out", led, 8'h3C);

        // random traffic against the address-map model
        m_ram[8'h10] = 8'hA5;
        m_known[8'h10] = 1'b1;
        m_led = 8'h3C;
        m_dig[0] = 8'h01;
        m_dig[1] = 8'h02;
        m_dig[2] = 8'h03;
        m_dig[3] = 8'h0F;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0: a = 8'($urandom_range(0, 31));
                1: a = 8'($urandom_range(240, 255));
                default: a = 8'($urandom_range(0, 255));
            endcase
            d = 8'($urandom);
            w = 1'($urandom);
            we = w;
            addr = a;
            di = d;
            #1;
            if (int'(a) >= RAM_DEPTH || m_known[a]) begin
                check("rand_rd", dout, model_rd(a));
            end
            check("rand_led", led, m_led);
            step();
            if (w) model_wr(a, d);
        end
        we = 1'b0;

        // button capture on btn_n[2]
        wr(IO, 8'hFF);
        btn_n[2] = 1'b0;
        addr = IO;
        for (int i = 1; i <= LAT; i++) begin
            step();
            if (i == LAT - 1) rd_chk("btn_early", IO, 8'h00);
        end
        rd_chk("btn_flag", IO, 8'h04);
        rd_chk("btn_level", IO + 8'd1, 8'h04);
        wr(IO, 8'h04);
        rd_chk("btn_clr", IO, 8'h00);
        repeat (6) step();
        rd_chk("btn_held", IO, 8'h00);
        btn_n[2] = 1'b1;
        repeat (LAT + 2) step();
        rd_chk("btn_rel_lvl", IO + 8'd1, 8'h00);
        rd_chk("btn_rel_flag", IO, 8'h00);
        btn_n[2] = 1'b0;
        repeat (LAT) step();
        rd_chk("btn_repress", IO, 8'h04);
        wr(IO, 8'h04);
        btn_n[2] = 1'b1;
        repeat (LAT + 2) step();
        rd_chk("btn_idle", IO, 8'h00);
        btn_n[2] = 1'b0;
        repeat (LAT - 1) step();
        wr(IO, 8'h04);
        rd_chk("btn_set_wins", IO, 8'h04);
        btn_n[2] = 1'b1;
        repeat (LAT + 2) step();
        wr(IO, 8'hFF);
        btn_n = 4'b0110;
        repeat (LAT) step();
        rd_chk("btn_multi", IO, 8'h09);
        btn_n = 4'hF;
        repeat (LAT + 2) step();
        wr(IO, 8'hFF);
        rd_chk("btn_multi_clr", IO, 8'h00);

`ifdef MMIO_DEBOUNCE_EN
        btn_n[0] = 1'b0;
        repeat (5) step();
        btn_n[0] = 1'b1;
        repeat (20) step();
        rd_chk("deb_glitch", IO, 8'h00);
        btn_n[0] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == LAT - 1) rd_chk("deb_early", IO, 8'h00);
            if (i == LAT) rd_chk("deb_flag", IO, 8'h01);
        end
        btn_n[0] = 1'b1;
        repeat (LAT + 2) step();
        wr(IO, 8'hFF);
`endif

        // scanner: reset, load digits, follow the slots
        rst = 1'b0;
        step();
        rst = 1'b1;
        wr(IO + 8'd3, 8'h01);
        wr(IO + 8'd4, 8'h02);
        wr(IO + 8'd5, 8'h03);
        wr(IO + 8'd6, 8'h0F);
        for (int c = 5; c <= 80; c++) begin
            if (c == 40) begin
                we = 1'b1;
                addr = IO + 8'd3;
                di = 8'h05;
            end else begin
                we = 1'b0;
            end
            step();
            we = 1'b0;
            case (c)
                15: check("scan15_dig", dig_n, 4'hF);
                16: begin
                    check("scan16_dig", dig_n, 4'b1110);
                    check("scan16_seg", seg_n, seg_tab[1]);
                end
                20: check("scan20_seg", seg_n, seg_tab[1]);
                32: begin
                    check("scan32_dig", dig_n, 4'b1101);
                    check("scan32_seg", seg_n, seg_tab[2]);
                end
                48: begin
                    check("scan48_dig", dig_n, 4'b1011);
                    check("scan48_seg", seg_n, seg_tab[3]);
                end
                64: begin
                    check("scan64_dig", dig_n, 4'b0111);
                    check("scan64_seg", seg_n, seg_tab[15]);
                end
                80: begin
                    check("scan80_dig", dig_n, 4'b1110);
                    check("scan80_seg", seg_n, seg_tab[5]);
                end
                default: ;
            endcase
        end

        // reset in the middle of a slot
        wr(IO + 8'd2, 8'h3C);
        repeat (6) step();
        rst = 1'b0;
        #1;
        check("mid_rst_seg", seg_n, 7'h7F);
        check("mid_rst_dig", dig_n, 4'hF);
        check("mid_rst_led", led, 8'h00);
        step();
        step();
        rst = 1'b1;
        rd_chk("post_rst_status", IO, 8'h00);
        rd_chk("post_rst_dig0", IO + 8'd3, 8'h00);
        rd_chk("post_rst_ram", 8'h10, m_ram[8'h10]);
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 15) check("post_rst15_dig", dig_n, 4'hF);
        end
        check("post_rst16_dig", dig_n, 4'b1110);
        check("post_rst16_seg", seg_n, seg_tab[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_memory.md
Name: mmio_memory

Overview:
- Parametrised successor to the CPU's plain data memory.
- Holds a data RAM plus a memory-mapped I/O window: button edge capture, an LED register, and a multiplexed hex 7-segment display scanner.
- Sits on the core's memory port: we/addr/di/do, with addr driven from the register file and di from the ALU.
- Combinational read keeps the single-cycle core timing unchanged.

Parameters:
- DATA_W, 8, data bus width (≥ 8).
- ADDR_W, 8, address width.
- RAM_DEPTH, 240, RAM words at addresses 0..RAM_DEPTH-1; must be ≤ IO_BASE.
- IO_BASE, 8'hF0, first I/O address.
- NUM_BTN, 4, button inputs (1..DATA_W).
- NUM_DIG, 4, display digits (1..8).
- SCAN_DIV, 16, clock cycles per digit slot (≥ 2).
- DEB_CYCLES, 8, stable cycles required with debounce enabled (≥ 2).

Ports:
- clk    in   1          system clock, all state on rising edge.
- rst    in   1          reset, asynchronous, active-low.
- we     in   1          write strobe.
- addr   in   ADDR_W     byte/word address.
- di     in   DATA_W     write data.
- do     out  DATA_W     read data, combinational from addr.
- btn_n  in   NUM_BTN    raw buttons, active-low, asynchronous.
- led    out  DATA_W     LED register contents.
- seg_n  out  7          segments g..a, active-low, registered.
- dig_n  out  NUM_DIG    digit enables, active-low one-hot, registered.

Behaviour:
- Reset (rst=0, async):
  - All I/O registers clear: BTN_STATUS=0, LED=0, DIGx=0.
  - seg_n=7'h7F and dig_n all ones (blank display).
  - Prescaler count=0; digit index=NUM_DIG-1.
  - Synchronisers load 1 (released).
  - RAM contents are not reset.
- Address map:
  - RAM: addr < RAM_DEPTH.
  - IO_BASE+0: BTN_STATUS. Read gives sticky press flags. Writing 1 to a bit clears that flag; writing 0 has no effect.
  - IO_BASE+1: BTN_LEVEL, read-only. Synchronised pressed levels, 1 = pressed.
  - IO_BASE+2: LED, read/write.
  - IO_BASE+3+k: DIGk for k < NUM_DIG, read/write. Low nibble is displayed as hex.
  - Any other address: reads return 0, writes are ignored. Upper unused status/level bits read 0.
- Write timing:
  - Writes take effect on the clock edge where we=1.
  - A read in the same cycle returns the old value.
- Button capture:
  - 2-flop synchroniser on ~btn_n.
  - Press edge = synchronised level 0→1; the flag sets one cycle after the second flop rises.
  - Press latency from btn_n falling edge to flag visible: 3 cycles.
  - Set and write-1-clear in the same cycle: set wins, flag stays 1.
  - Holding a button does not re-set the flag after it has been cleared.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On a tick (count == SCAN_DIV-1), idx ← (idx+1) mod NUM_DIG.
  - On the same tick, dig_n ← ~(1<<new idx) and seg_n ← hex7(DIGnew[3:0]).
  - First lit digit is 0, at cycle SCAN_DIV after reset release.
  - A DIG register written mid-slot becomes visible at that digit's next slot.
  - hex7 covers 0–F, active-low, standard segment set.
- Reset mid-operation: everything above returns to its reset values immediately; the display blanks.

Optional Feature:
- Macro: MMIO_DEBOUNCE_EN.
- Defined:
  - Each synchronised level must be stable for DEB_CYCLES consecutive cycles before the debounced level changes.
  - Edge detect and BTN_LEVEL use the debounced level.
  - Press latency = 2 + DEB_CYCLES + 1 cycles.
  - Glitches shorter than DEB_CYCLES are ignored.
- Undefined: no debounce counters; behaviour is exactly as in Behaviour.

Decomposition:
- Package mmio_pkg:
  - Offset constants OFS_BTN_STATUS=0, OFS_BTN_LEVEL=1, OFS_LED=2, OFS_DIG0=3.
  - hex7 segment constant table (16 entries × 7 bits).
  - Blank constant SEG_OFF=7'h7F.
- Sub-module btn_capture, one instance per button (generate loop):
  - Contains the synchroniser, the optional debounce counter, level output and press pulse.
  - Parent holds the sticky flags, RAM, registers and scanner.

Test Plan:
- Reset: assert rst=0 mid-scan → seg_n=7'h7F, dig_n=4'hF, LED=0; after release, do at IO_BASE+0 = 0.
- RAM: write 8'hA5 to addr 8'h10, then read addr 8'h10 → do=8'hA5; read addr 8'hF9 (unmapped) → 0; write to 8'hF9 has no effect on any readback.
- Button:
  - btn_n[2] held low → BTN_STATUS=8'h04 three cycles later; BTN_LEVEL=8'h04.
  - Write 8'h04 to BTN_STATUS → 0, stays 0 while still held.
  - Release and press again → flag set again.
  - Simultaneous press edge and clear write → flag reads 1.
- Scan: DIG0..3 = 1,2,3,F with SCAN_DIV=16:
  - cycle 16: dig_n=4'b1110, seg_n=hex7(1).
  - cycle 32: 4'b1101, hex7(2).
  - cycle 64: 4'b0111, hex7(F).
  - cycle 80: wraps back to digit 0.
- LED: write 8'h3C to IO_BASE+2 → led=8'h3C the next cycle; readback 8'h3C.
- MMIO_DEBOUNCE_EN, DEB_CYCLES=8:
  - 5-cycle low pulse on btn_n[0] → no flag.
  - 20-cycle low → flag set at cycle 11 after the falling edge.
